alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal 2..8).
REQ-002 SHALL have parameter IDW, default $clog2(NREQ), width of the requester index.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NREQ  per-requester operation valid.
REQ-006 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_op  in  NREQ x 3  per-requester alucontrol code.
REQ-008 req_a, req_b  in  NREQ x 32  per-requester operands.
REQ-009 rsp_valid  out  1  response register holds a result.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_id  out  IDW  index of requester that issued the response.
REQ-012 rsp_result  out  32  ALU result.
REQ-013 rsp_zero  out  1  result == 0.
REQ-014 rsp_illegal  out  1  op was not one of 000, 001, 010, 011, 101.

Function
REQ-015 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i] in the same cycle.
REQ-016 Output stage SHALL be free when !rsp_valid || rsp_ready (same-cycle drain-and-refill allowed).
REQ-017 req_ready[i] SHALL be high only when stage free, req_valid[i] high, and i is the arbitration winner; req_ready SHALL NOT depend on rsp_valid of another cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on a transfer.
REQ-019 Granted operands SHALL drive one shared ALU combinationally; result, zero, op-legality and id SHALL be registered on transfer; latency exactly 1 cycle (rsp_valid high the cycle after transfer).
REQ-020 Illegal op: rsp_result SHALL be 32'h0, rsp_zero 1, rsp_illegal 1; no X SHALL reach outputs.
REQ-021 SLT (101) SHALL be signed compare; ADD/SUB SHALL wrap mod 2^32 with no overflow flag.
REQ-022 While rsp_valid && !rsp_ready, all rsp_* outputs SHALL hold stable and req_ready SHALL be all-zero.
REQ-023 Response consumed with no new transfer SHALL clear rsp_valid next cycle.
REQ-024 No requests valid: req_ready all-zero, last_grant unchanged.
REQ-025 A requester SHALL be allowed to drop req_valid without a transfer; no state changes.

Reset
REQ-026 On reset: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_illegal 0, last_grant NREQ-1 (so requester 0 wins first).
REQ-027 Reset mid-operation SHALL discard any held response; req_ready SHALL be all-zero during the reset cycle.

Configuration
REQ-028 Macro ALU_ARBITER_RR_EN: defined -> round-robin per REQ-018; undefined -> fixed priority, lowest index wins, last_grant absent, all else identical.

Structure
REQ-029 Shared package SHALL hold the alucontrol enum (ADD 000, SUB 001, AND 010, OR 011, SLT 101) and a legality function.
REQ-030 Shared datapath SHALL be the existing alu module, instantiated once; arbiter logic SHALL stay in alu_arbiter.

Verification
REQ-031 Single req: req0 ADD a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=12, zero=0.
REQ-032 Contention (RR): req0 and req1 valid continuously, rsp_ready=1 -> grants 0,1,0,1; fixed-priority build -> 0,0,0,0.
REQ-033 Backpressure: rsp_ready=0 for 3 cycles after a SUB 9-9 -> rsp_result=0, zero=1 held stable, req_ready=0 throughout; then drain-and-refill in one cycle.
REQ-034 Signed SLT: a=32'hFFFFFFFF, b=1 -> result=1; a=1, b=32'hFFFFFFFF -> result=0, zero=1.
REQ-035 Illegal op 110 -> result=0, zero=1, illegal=1; reset asserted with rsp_valid=1 -> rsp_valid=0 next cycle, next grant goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU control encodings and the op legality check used by the arbiter.
package alu_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Shared 32-bit ALU; undefined control codes produce a clean zero result.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'h0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'h0, $signed(a) < $signed(b)};
            default: result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/alu_arbiter.sv
// N-requester front end sharing one ALU with a single registered response slot.
// ALU_ARBITER_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][2:0]        req_op,
    input  logic [NREQ-1:0][31:0]       req_a,
    input  logic [NREQ-1:0][31:0]       req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [31:0]                 rsp_result,
    output logic                        rsp_zero,
    output logic                        rsp_illegal
);

    logic            stage_free;
    logic            xfer;
    logic [IDW-1:0]  win;
    logic [31:0]     alu_result;
    logic            alu_zero;

`ifdef ALU_ARBITER_RR_EN
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  cand;

    // Walk offsets from farthest to nearest so the nearest valid one sticks.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(last_grant) + 1 + k) % NREQ);
            if (req_valid[cand]) win = cand;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[k]) win = IDW'(k);
    end
`endif

    assign stage_free = !rsp_valid || rsp_ready;
    assign xfer       = (|req_valid) && stage_free && !reset;
    assign req_ready  = xfer ? (NREQ'(1) << win) : '0;

    alu u_alu (
        .op     (req_op[win]),
        .a      (req_a[win]),
        .b      (req_b[win]),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= 32'h0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
            last_grant  <= IDW'(NREQ - 1);
`endif
        end else if (xfer) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= win;
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= !op_legal(req_op[win]);
`ifdef ALU_ARBITER_RR_EN
            last_grant  <= win;
`endif
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NREQ=2), valid for both arbitration builds.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
`ifdef ALU_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][2:0]  req_op;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
    logic                  rsp_illegal;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        step(); step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0d want 0", rsp_id); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", rsp_result); end
        checks++; if (rsp_zero !== 1'b0 || rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got z=%b i=%b want 0 0", rsp_zero, rsp_illegal); end
        req_valid = 2'b11; rsp_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
        req_valid = '0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_op[0] = 3'b000; req_a[0] = 32'd5; req_b[0] = 32'd7; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL single_vid got v=%b id=%0d want 1 0", rsp_valid, rsp_id); end
        checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_illegal !== 1'b0) begin errors++; $display("FAIL single_result got %0d z=%b i=%b want 12 0 0", rsp_result, rsp_zero, rsp_illegal); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [IDW-1:0]  exp_id;
        logic [NREQ-1:0] exp_rdy;
        reset = 1'b1; step(); reset = 1'b0;
        req_valid = 2'b11; rsp_ready = 1'b1;
        req_op[0] = 3'b000; req_a[0] = 32'd10; req_b[0] = 32'd1;
        req_op[1] = 3'b000; req_a[1] = 32'd20; req_b[1] = 32'd2;
        for (int k = 0; k < 4; k++) begin
            exp_id  = RR ? IDW'(k % 2) : 1'b0;
            exp_rdy = (exp_id == 1'b1) ? 2'b10 : 2'b01;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contend_ready[%0d] got %b want %b", k, req_ready, exp_rdy); end
            step();
            checks++; if (rsp_id !== exp_id || rsp_result !== (exp_id == 1'b1 ? 32'd22 : 32'd11)) begin
                errors++; $display("FAIL contend_rsp[%0d] got id=%0d res=%0d want id=%0d", k, rsp_id, rsp_result, exp_id);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        req_valid = 2'b01; req_op[0] = 3'b001; req_a[0] = 32'd9; req_b[0] = 32'd9; rsp_ready = 1'b0;
        step();
        req_op[0] = 3'b000; req_a[0] = 32'd3; req_b[0] = 32'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b want 00", k, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b res=%h z=%b id=%0d want 1 0 1 0", k, rsp_valid, rsp_result, rsp_zero, rsp_id);
            end
            step();
        end
        rsp_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_refill_ready got %b want 01", req_ready); end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_zero !== 1'b0) begin errors++; $display("FAIL bp_refill got v=%b res=%0d z=%b want 1 7 0", rsp_valid, rsp_result, rsp_zero); end
        step();
    endtask

    task automatic test_slt();
        req_valid = 2'b10; rsp_ready = 1'b1;
        req_op[1] = 3'b101; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
        step();
        req_a[1] = 32'd1; req_b[1] = 32'hFFFF_FFFF;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL slt_neg got v=%b id=%0d res=%0d z=%b want 1 1 1 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
            errors++; $display("FAIL slt_pos got v=%b res=%0d z=%b want 1 0 1", rsp_valid, rsp_result, rsp_zero);
        end
        step();
    endtask

    task automatic test_illegal_reset();
        req_valid = 2'b01; req_op[0] = 3'b110; req_a[0] = 32'd5; req_b[0] = 32'd3; rsp_ready = 1'b1;
        step();
        req_valid = '0; rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_zero !== 1'b1 || rsp_illegal !== 1'b1) begin
            errors++; $display("FAIL illegal got v=%b res=%h z=%b i=%b want 1 0 1 1", rsp_valid, rsp_result, rsp_zero, rsp_illegal);
        end
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        req_op[0] = 3'b000; req_a[0] = 32'd1; req_b[0] = 32'd1;
        req_op[1] = 3'b000; req_a[1] = 32'd2; req_b[1] = 32'd2;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midreset_ready got %b want 00", req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b0 || rsp_illegal !== 1'b0) begin errors++; $display("FAIL midreset_clear got v=%b i=%b want 0 0", rsp_valid, rsp_illegal); end
        reset = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready got %b want 01", req_ready); end
        step();
        req_valid = '0;
        checks++; if (rsp_id !== 1'b0 || rsp_result !== 32'd2) begin errors++; $display("FAIL post_reset_rsp got id=%0d res=%0d want 0 2", rsp_id, rsp_result); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_slt();
        test_illegal_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
